// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch FIFO fed by a fixed one-cycle-latency instruction memory
// Ports: clk/reset (sync, active-high); o_imem_req_en/o_imem_req_addr issue fetches,
//   i_imem_res_data returns the word one cycle later; o_instr_valid/o_instr_data/o_instr_addr
//   present the head entry, popped by i_instr_ready; i_redirect_en/i_redirect_addr flush and
//   restart fetch. Defining FETCH_BUFFER_STATS_EN adds o_bubble_count (pipeline starvation cycles).
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter logic [`ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [`ADDR_W-1:0] o_imem_req_addr,
  output logic               o_imem_req_en,
  input  logic [`WORD_W-1:0] i_imem_res_data,
  output logic               o_instr_valid,
  output logic [`WORD_W-1:0] o_instr_data,
  output logic [`ADDR_W-1:0] o_instr_addr,
  input  logic               i_instr_ready,
  input  logic               i_redirect_en,
  input  logic [`ADDR_W-1:0] i_redirect_addr
`ifdef FETCH_BUFFER_STATS_EN
  ,
  output logic [15:0]        o_bubble_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  logic [`ADDR_W-1:0] r_pc;
  logic [`ADDR_W-1:0] r_req_addr;
  logic [AW:0] r_count;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic r_inflight;
  logic [`WORD_W+`ADDR_W-1:0] r_mem [DEPTH];
  logic [AW:0] w_occ;
  logic w_push;
  logic w_pop;
  // Occupancy counts the outstanding response so a full FIFO can never be overrun.
  assign w_occ = r_count + {{AW{1'b0}}, r_inflight};
  assign o_imem_req_en = !reset && !i_redirect_en && (w_occ < DEPTH_L);
  assign o_imem_req_addr = r_pc;
  assign o_instr_valid = r_count != '0;
  assign {o_instr_data, o_instr_addr} = r_mem[r_rd];
  // A redirect squashes the response returning in its own cycle; no request is issued in
  // that cycle, so clearing the inflight flag is all that is needed to drop stale data.
  assign w_push = r_inflight && !i_redirect_en;
  assign w_pop = o_instr_valid && i_instr_ready && !i_redirect_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_ADDR;
      r_count <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_inflight <= 1'b0;
    end else if (i_redirect_en) begin
      r_pc <= i_redirect_addr;
      r_count <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_imem_req_en;
      if (o_imem_req_en) begin
        r_pc <= r_pc + `ADDR_W'(4);
        r_req_addr <= r_pc;
      end
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr] <= {i_imem_res_data, r_req_addr};
  end
`ifdef FETCH_BUFFER_STATS_EN
  logic [15:0] r_bubble;
  always_ff @(posedge clk) begin
    if (reset) r_bubble <= '0;
    else if (i_instr_ready && !o_instr_valid && r_bubble != 16'hFFFF) r_bubble <= r_bubble + 16'd1;
  end
  assign o_bubble_count = r_bubble;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer (DEPTH=4, RESET_ADDR=0)
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
module tb_fetch_buffer;
  localparam int A = `ADDR_W;
  localparam int W = `WORD_W;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [A-1:0] o_imem_req_addr;
  logic o_imem_req_en;
  logic [W-1:0] i_imem_res_data = '0;
  logic o_instr_valid;
  logic [W-1:0] o_instr_data;
  logic [A-1:0] o_instr_addr;
  logic i_instr_ready = 1'b0;
  logic i_redirect_en = 1'b0;
  logic [A-1:0] i_redirect_addr = '0;
`ifdef FETCH_BUFFER_STATS_EN
  logic [15:0] o_bubble_count;
`endif
  int vecs = 0;
  int fails = 0;
  logic p_req = 1'b0;
  logic [A-1:0] p_addr = '0;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk(clk),
    .reset(reset),
    .o_imem_req_addr(o_imem_req_addr),
    .o_imem_req_en(o_imem_req_en),
    .i_imem_res_data(i_imem_res_data),
    .o_instr_valid(o_instr_valid),
    .o_instr_data(o_instr_data),
    .o_instr_addr(o_instr_addr),
    .i_instr_ready(i_instr_ready),
    .i_redirect_en(i_redirect_en),
    .i_redirect_addr(i_redirect_addr)
`ifdef FETCH_BUFFER_STATS_EN
    ,
    .o_bubble_count(o_bubble_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [W-1:0] f(input logic [A-1:0] a);
    return W'(a) * W'(32'h9E3779B1) + W'(32'h12345678);
  endfunction

  // Advance one cycle: memory answers last cycle's request, new inputs applied, outputs settle.
  task automatic cyc(input logic rst, input logic rdy, input logic rd, input logic [A-1:0] ra);
    @(posedge clk);
    #1;
    i_imem_res_data = p_req ? f(p_addr) : W'($urandom);
    reset = rst;
    i_instr_ready = rdy;
    i_redirect_en = rd;
    i_redirect_addr = ra;
    #1;
    p_req = o_imem_req_en;
    p_addr = o_imem_req_addr;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'($urandom), 1'b0, '0);
      vecs++;
      if (o_imem_req_en !== 1'b0) begin fails++; $display("FAIL reset_req_en k=%0d: got %b want 0", k, o_imem_req_en); end
      vecs++;
      if (o_instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid k=%0d: got %b want 0", k, o_instr_valid); end
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    vecs++;
    if (o_imem_req_en !== 1'b1 || o_imem_req_addr !== '0) begin fails++; $display("FAIL reset_first_req: got en=%b addr=%h want en=1 addr=0", o_imem_req_en, o_imem_req_addr); end
  endtask

  task automatic test_stream;
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      vecs++;
      if (o_imem_req_en !== 1'b1 || o_imem_req_addr !== A'(4*k)) begin fails++; $display("FAIL stream_req k=%0d: got en=%b addr=%h want en=1 addr=%h", k, o_imem_req_en, o_imem_req_addr, A'(4*k)); end
      vecs++;
      if (o_instr_valid !== 1'(k >= 2)) begin fails++; $display("FAIL stream_valid k=%0d: got %b want %b", k, o_instr_valid, k >= 2); end
      if (k >= 2) begin
        vecs++;
        if (o_instr_addr !== A'(4*(k-2)) || o_instr_data !== f(A'(4*(k-2)))) begin fails++; $display("FAIL stream_head k=%0d: got addr=%h data=%h want addr=%h data=%h", k, o_instr_addr, o_instr_data, A'(4*(k-2)), f(A'(4*(k-2)))); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic er;
    logic [A-1:0] ea;
    logic [A-1:0] eh;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 11; k++) begin
      cyc(1'b0, 1'(k == 8), 1'b0, '0);
      er = (k < 4) || (k == 9);
      ea = (k < 4) ? A'(4*k) : A'(32'h10);
      eh = (k >= 9) ? A'(4) : A'(0);
      vecs++;
      if (o_imem_req_en !== er) begin fails++; $display("FAIL bp_req_en k=%0d: got %b want %b", k, o_imem_req_en, er); end
      if (er) begin
        vecs++;
        if (o_imem_req_addr !== ea) begin fails++; $display("FAIL bp_req_addr k=%0d: got %h want %h", k, o_imem_req_addr, ea); end
      end
      vecs++;
      if (o_instr_valid !== 1'(k >= 2)) begin fails++; $display("FAIL bp_valid k=%0d: got %b want %b", k, o_instr_valid, k >= 2); end
      if (k >= 2) begin
        vecs++;
        if (o_instr_addr !== eh || o_instr_data !== f(eh)) begin fails++; $display("FAIL bp_head k=%0d: got addr=%h data=%h want addr=%h data=%h", k, o_instr_addr, o_instr_data, eh, f(eh)); end
      end
    end
  endtask

  task automatic test_redirect;
    logic er;
    logic ev;
    logic [A-1:0] ea;
    logic [A-1:0] eh;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'(k == 8), 1'(k == 4), A'(32'h40));
      er = k != 4;
      ea = (k < 4) ? A'(4*k) : A'(32'h40 + 4*(k-5));
      ev = (k >= 2 && k <= 4) || k >= 7;
      eh = (k <= 4) ? A'(0) : (k == 9) ? A'(32'h44) : A'(32'h40);
      vecs++;
      if (o_imem_req_en !== er) begin fails++; $display("FAIL redir_req_en k=%0d: got %b want %b", k, o_imem_req_en, er); end
      if (er) begin
        vecs++;
        if (o_imem_req_addr !== ea) begin fails++; $display("FAIL redir_req_addr k=%0d: got %h want %h", k, o_imem_req_addr, ea); end
      end
      vecs++;
      if (o_instr_valid !== ev) begin fails++; $display("FAIL redir_valid k=%0d: got %b want %b", k, o_instr_valid, ev); end
      if (ev) begin
        vecs++;
        if (o_instr_addr !== eh || o_instr_data !== f(eh)) begin fails++; $display("FAIL redir_head k=%0d: got addr=%h data=%h want addr=%h data=%h", k, o_instr_addr, o_instr_data, eh, f(eh)); end
      end
    end
  endtask

  task automatic test_wrap;
    logic er;
    logic ev;
    logic [A-1:0] ea;
    logic [A-1:0] eh;
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'(k == 4 || k == 5), (k == 4) ? A'(32'h100) : ~A'(3));
      er = k != 4 && k != 5;
      ea = (k < 4) ? A'(4*k) : A'(4*k - 28);
      ev = (k >= 2 && k <= 4) || k >= 8;
      eh = (k <= 4) ? A'(4*(k-2)) : A'(4*k - 36);
      vecs++;
      if (o_imem_req_en !== er) begin fails++; $display("FAIL wrap_req_en k=%0d: got %b want %b", k, o_imem_req_en, er); end
      if (er) begin
        vecs++;
        if (o_imem_req_addr !== ea) begin fails++; $display("FAIL wrap_req_addr k=%0d: got %h want %h", k, o_imem_req_addr, ea); end
      end
      vecs++;
      if (o_instr_valid !== ev) begin fails++; $display("FAIL wrap_valid k=%0d: got %b want %b", k, o_instr_valid, ev); end
      if (ev) begin
        vecs++;
        if (o_instr_addr !== eh || o_instr_data !== f(eh)) begin fails++; $display("FAIL wrap_head k=%0d: got addr=%h data=%h want addr=%h data=%h", k, o_instr_addr, o_instr_data, eh, f(eh)); end
      end
    end
  endtask

  task automatic test_reset_full;
    logic er;
    logic ev;
    logic [A-1:0] ea;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 13; k++) begin
      cyc(1'(k == 8 || k == 9), 1'b0, 1'b0, '0);
      er = k < 4 || k >= 10;
      ea = (k < 4) ? A'(4*k) : A'(4*(k-10));
      ev = (k >= 2 && k <= 7) || k == 12;
      vecs++;
      if (o_imem_req_en !== er) begin fails++; $display("FAIL rstfull_req_en k=%0d: got %b want %b", k, o_imem_req_en, er); end
      if (er) begin
        vecs++;
        if (o_imem_req_addr !== ea) begin fails++; $display("FAIL rstfull_req_addr k=%0d: got %h want %h", k, o_imem_req_addr, ea); end
      end
      if (k != 8) begin
        vecs++;
        if (o_instr_valid !== ev) begin fails++; $display("FAIL rstfull_valid k=%0d: got %b want %b", k, o_instr_valid, ev); end
      end
      if (ev) begin
        vecs++;
        if (o_instr_addr !== '0 || o_instr_data !== f('0)) begin fails++; $display("FAIL rstfull_head k=%0d: got addr=%h data=%h want addr=0 data=%h", k, o_instr_addr, o_instr_data, f('0)); end
      end
    end
  endtask

  // Reference: a queue of buffered addresses plus at most one pending fetch.
  task automatic test_random;
    logic [A-1:0] q[$];
    logic pv;
    logic [A-1:0] pa;
    logic [A-1:0] pc;
    logic [15:0] bub;
    logic rst;
    logic rd;
    logic rdy;
    logic [A-1:0] ra;
    logic m_req;
    logic m_valid;
    cyc(1'b1, 1'b0, 1'b0, '0);
    pv = 1'b0;
    pa = '0;
    pc = '0;
    bub = '0;
    for (int k = 0; k < 400; k++) begin
      rst = $urandom_range(0, 49) == 0;
      rd = $urandom_range(0, 11) == 0;
      rdy = 1'($urandom_range(0, 1));
      ra = $urandom_range(0, 1) ? (A'($urandom) & ~A'(3)) : (A'(0) - A'(4*$urandom_range(1, 3)));
      cyc(rst, rdy, rd, ra);
      m_req = !rst && !rd && (q.size() + int'(pv) < DEPTH);
      m_valid = q.size() != 0;
      vecs++;
      if (o_imem_req_en !== m_req) begin fails++; $display("FAIL rand_req_en k=%0d: got %b want %b", k, o_imem_req_en, m_req); end
      if (m_req) begin
        vecs++;
        if (o_imem_req_addr !== pc) begin fails++; $display("FAIL rand_req_addr k=%0d: got %h want %h", k, o_imem_req_addr, pc); end
      end
      vecs++;
      if (o_instr_valid !== m_valid) begin fails++; $display("FAIL rand_valid k=%0d: got %b want %b", k, o_instr_valid, m_valid); end
      if (m_valid) begin
        vecs++;
        if (o_instr_addr !== q[0] || o_instr_data !== f(q[0])) begin fails++; $display("FAIL rand_head k=%0d: got addr=%h data=%h want addr=%h data=%h", k, o_instr_addr, o_instr_data, q[0], f(q[0])); end
      end
`ifdef FETCH_BUFFER_STATS_EN
      vecs++;
      if (o_bubble_count !== bub) begin fails++; $display("FAIL rand_bubble k=%0d: got %0d want %0d", k, o_bubble_count, bub); end
`endif
      if (rst) begin
        q.delete();
        pv = 1'b0;
        pc = '0;
        bub = '0;
      end else begin
        if (rdy && !m_valid && bub != 16'hFFFF) bub = bub + 16'd1;
        if (rd) begin
          q.delete();
          pv = 1'b0;
          pc = ra;
        end else begin
          if (rdy && m_valid) void'(q.pop_front());
          if (pv) q.push_back(pa);
          pv = m_req;
          if (m_req) begin
            pa = pc;
            pc = pc + A'(4);
          end
        end
      end
    end
  endtask

`ifdef FETCH_BUFFER_STATS_EN
  task automatic test_bubble;
    int eb[10] = '{0, 1, 2, 2, 2, 2, 2, 3, 4, 0};
    cyc(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'(k == 8), 1'b1, 1'(k == 5), A'(32'h200));
      vecs++;
      if (o_bubble_count !== 16'(eb[k])) begin fails++; $display("FAIL bubble k=%0d: got %0d want %0d", k, o_bubble_count, eb[k]); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_wrap;
    test_reset_full;
`ifdef FETCH_BUFFER_STATS_EN
    test_bubble;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, >= 2.
REQ-002 SHALL have parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port o_imem_req_addr  output  `ADDR_W  fetch address to instruction memory.
REQ-006 SHALL have port o_imem_req_en  output  1  fetch request strobe.
REQ-007 SHALL have port i_imem_res_data  input  `WORD_W  instruction word, valid the cycle after a strobed request.
REQ-008 SHALL have port o_instr_valid  output  1  head entry available to the pipeline.
REQ-009 SHALL have port o_instr_data  output  `WORD_W  head entry instruction word.
REQ-010 SHALL have port o_instr_addr  output  `ADDR_W  head entry fetch address.
REQ-011 SHALL have port i_instr_ready  input  1  pipeline accepts head entry.
REQ-012 SHALL have port i_redirect_en  input  1  flush and restart fetch.
REQ-013 SHALL have port i_redirect_addr  input  `ADDR_W  restart address.

Function
REQ-014 SHALL treat instruction memory as fixed one-cycle latency: request strobed in cycle N returns data in cycle N+1, no backpressure.
REQ-015 SHALL hold fetch PC register; each issued request uses PC, then PC += 4, wrapping modulo 2^`ADDR_W.
REQ-016 SHALL assert o_imem_req_en iff not reset, not i_redirect_en, and registered (count + inflight) < DEPTH; no same-cycle pop credit.
REQ-017 SHALL set inflight flag at the edge a request issues; clear it at the edge its data returns.
REQ-018 SHALL push {returned data, request address} into FIFO at end of return cycle unless squashed.
REQ-019 SHALL drive o_instr_valid = (count != 0) from registered state only; no empty-FIFO bypass.
REQ-020 SHALL pop head at the edge where o_instr_valid and i_instr_ready are both 1.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL never push into a full FIFO (guaranteed by REQ-016); read/write pointers wrap at DEPTH.
REQ-023 SHALL, on i_redirect_en=1 in cycle R: clear FIFO, set PC = i_redirect_addr, mark any in-flight response squashed (discarded in R+1), suppress request in R.
REQ-024 SHALL give redirect priority over pop and push in cycle R; handshake in R is a no-op.
REQ-025 SHALL, after redirect in R, issue i_redirect_addr in R+1 and assert o_instr_valid in R+3.
REQ-026 SHALL accept back-to-back redirects; the last one wins.

Reset
REQ-027 SHALL, while reset=1: o_imem_req_en=0, o_instr_valid=0, count=0, pointers=0, inflight=0, PC=RESET_ADDR.
REQ-028 SHALL issue RESET_ADDR in the first cycle with reset=0.
REQ-029 SHALL, on reset mid-operation, discard all buffered and in-flight data, with o_instr_valid=0 from the next cycle.
REQ-030 SHALL drive o_instr_data/o_instr_addr as don't-care while o_instr_valid=0.

Configuration
REQ-031 SHALL, with FETCH_BUFFER_STATS_EN defined, add output o_bubble_count (16 bits): cycles with i_instr_ready=1 and o_instr_valid=0, saturating at 0xFFFF, cleared by reset and not by redirect.
REQ-032 SHALL, without FETCH_BUFFER_STATS_EN, omit o_bubble_count port and logic entirely; all other behaviour identical.

Verification (DEPTH=4, RESET_ADDR=0)
REQ-033 SHALL cover: reset release, ready=1 always -> requests 0x0,0x4,0x8... every cycle; first valid 2 cycles after first request, addr 0x0; one instruction per cycle thereafter.
REQ-034 SHALL cover: ready=0 from reset -> exactly 4 requests (0x0-0xC), then req_en=0; single ready pulse pops 0x0, next request 0x10 issued the cycle after.
REQ-035 SHALL cover: redirect to 0x40 with 3 entries and 1 in flight -> returned word discarded, valid=0 until R+3, head addr 0x40.
REQ-036 SHALL cover: redirect to 2^`ADDR_W-4 -> requests 2^`ADDR_W-4 then 0x0; delivered addresses in that order.
REQ-037 SHALL cover: reset asserted with FIFO full -> valid=0 and req_en=0 next cycle; after release, first request 0x0.
REQ-038 SHALL cover, with FETCH_BUFFER_STATS_EN: ready=1 from reset release -> o_bubble_count=2 when first instruction valid; unchanged on redirect, 0 after reset.
